// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - Decode/instruction-memory signal bundle for fetch_queue
// if_misalign exists only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_queue_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int IMEM_AW = 7
);
    logic                       id_stall;
    logic                       id_if_selpcsource;
    logic [1:0]                 id_if_selpctype;
    logic [ADDR_W-1:0]          id_if_rega;
    logic [ADDR_W-1:0]          id_if_pcimd2ext;
    logic [ADDR_W-1:0]          id_if_pcindex;
    logic                       imem_req;
    logic [IMEM_AW-1:0]         imem_addr;
    logic [DATA_W-1:0]          imem_rdata;
    logic                       if_id_valid;
    logic [DATA_W-1:0]          if_id_instruc;
    logic [ADDR_W-1:0]          if_id_nextpc;
    logic [$clog2(DEPTH):0]     fq_count;
`ifdef FETCH_ALIGN_CHECK_EN
    logic                       if_misalign;
`endif

    modport master (
        input  id_stall, id_if_selpcsource, id_if_selpctype,
        input  id_if_rega, id_if_pcimd2ext, id_if_pcindex, imem_rdata,
`ifdef FETCH_ALIGN_CHECK_EN
        output if_misalign,
`endif
        output imem_req, imem_addr, if_id_valid, if_id_instruc, if_id_nextpc, fq_count
    );

    modport slave (
        output id_stall, id_if_selpcsource, id_if_selpctype,
        output id_if_rega, id_if_pcimd2ext, id_if_pcindex, imem_rdata,
`ifdef FETCH_ALIGN_CHECK_EN
        input  if_misalign,
`endif
        input  imem_req, imem_addr, if_id_valid, if_id_instruc, if_id_nextpc, fq_count
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with DEPTH-entry prefetch queue and redirect flush
// Optional misaligned-redirect trap enabled by FETCH_ALIGN_CHECK_EN.
module fetch_queue #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 4,
    parameter int                IMEM_AW    = 7,
    parameter logic [ADDR_W-1:0] RESET_PC   = 'h0000_0000,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 'h0000_0040
) (
    input  logic          clock,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_tag;

    logic [DATA_W-1:0] q_instr  [DEPTH];
    logic [ADDR_W-1:0] q_nextpc [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_nextpc;

    logic              redirect;
    logic [ADDR_W-1:0] target_raw;
    logic [ADDR_W-1:0] target;
    logic [CW:0]       credit;
    logic              issue;
    logic              pop;
    logic              bypass;
    logic              push;

    assign redirect = bus.id_if_selpcsource;

    always_comb begin
        target_raw = bus.id_if_pcimd2ext;
        case (bus.id_if_selpctype)
            2'b00:   target_raw = bus.id_if_pcimd2ext;
            2'b01:   target_raw = bus.id_if_rega;
            2'b10:   target_raw = bus.id_if_pcindex;
            default: target_raw = EXC_VECTOR;
        endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    logic misalign_q;

    assign misaligned = (target_raw[1:0] != 2'b00);
    assign target     = misaligned ? EXC_VECTOR : target_raw;

    always_ff @(posedge clock) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect && misaligned;
        end
    end

    assign bus.if_misalign = misalign_q;
`else
    assign target = target_raw & ~ADDR_W'(3);
`endif

    // Credit counts the in-flight word too, so a push can never overflow the queue.
    assign credit = {1'b0, count} + (CW+1)'(inflight);
    assign issue  = !reset && !redirect && (credit < (CW+1)'(DEPTH));

    always_comb begin
        pop    = 1'b0;
        bypass = 1'b0;
        push   = 1'b0;
        if (!reset && !redirect) begin
            pop    = !bus.id_stall && (count != '0);
            bypass = !bus.id_stall && (count == '0) && inflight;
            push   = inflight && !bypass;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_instr[wr_ptr]  <= bus.imem_rdata;
            q_nextpc[wr_ptr] <= inflight_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc           <= RESET_PC;
            inflight     <= 1'b0;
            inflight_tag <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            out_valid    <= 1'b0;
            out_instr    <= '0;
            out_nextpc   <= '0;
        end else if (redirect) begin
            // Flush: the in-flight response is dropped by clearing inflight.
            pc         <= target;
            inflight   <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_nextpc <= target;
        end else begin
            if (issue) begin
                pc           <= pc + ADDR_W'(4);
                inflight     <= 1'b1;
                inflight_tag <= pc + ADDR_W'(4);
            end else begin
                inflight <= 1'b0;
            end

            if (!bus.id_stall) begin
                if (pop) begin
                    out_valid  <= 1'b1;
                    out_instr  <= q_instr[rd_ptr];
                    out_nextpc <= q_nextpc[rd_ptr];
                end else if (bypass) begin
                    out_valid  <= 1'b1;
                    out_instr  <= bus.imem_rdata;
                    out_nextpc <= inflight_tag;
                end else begin
                    out_valid  <= 1'b0;
                end
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign bus.imem_req      = issue;
    assign bus.imem_addr     = pc[IMEM_AW+1:2];
    assign bus.if_id_valid   = out_valid;
    assign bus.if_id_instruc = out_instr;
    assign bus.if_id_nextpc  = out_nextpc;
    assign bus.fq_count      = count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed table-driven bench for fetch_queue
// Memory word n returns 32'hA000_0000 + n.
module tb_fetch_queue;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .IMEM_AW(7)) bus ();

    fetch_queue #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .IMEM_AW(7),
        .RESET_PC(32'h0000_0000), .EXC_VECTOR(32'h0000_0040)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always @(posedge clock) begin
        if (bus.imem_req) begin
            bus.imem_rdata <= 32'hA000_0000 + {25'd0, bus.imem_addr};
        end
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        sel;
        logic [1:0]  typ;
        logic [31:0] tgt;
        logic        req;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] nextpc;
        logic [2:0]  count;
    } vec_t;

    vec_t tv[21];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic last_req;

    function automatic vec_t mk(input logic r, st, s, input logic [1:0] ty, input logic [31:0] tg,
                                input logic rq, v, input logic [31:0] ins, npc, input logic [2:0] c);
        vec_t x;
        x.rst = r; x.stall = st; x.sel = s; x.typ = ty; x.tgt = tg;
        x.req = rq; x.valid = v; x.instr = ins; x.nextpc = npc; x.count = c;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs; imem_req is sampled mid-cycle, outputs 1 time unit after the edge.
    task automatic cyc(input logic r, st, s, input logic [1:0] ty, input logic [31:0] tg);
        reset                 = r;
        bus.id_stall          = st;
        bus.id_if_selpcsource = s;
        bus.id_if_selpctype   = ty;
        bus.id_if_pcimd2ext   = 32'h0000_0180;
        bus.id_if_rega        = 32'h0000_01C0;
        bus.id_if_pcindex     = 32'h0000_01E0;
        case (ty)
            2'b00:   bus.id_if_pcimd2ext = tg;
            2'b01:   bus.id_if_rega      = tg;
            2'b10:   bus.id_if_pcindex   = tg;
            default: ;
        endcase
        @(negedge clock);
        last_req = bus.imem_req;
        @(posedge clock);
        #1;
    endtask

    task automatic redirect_seq(input string nm, input logic [1:0] ty, input logic [31:0] tg,
                                input logic st, input logic [31:0] exp_pc, input logic [31:0] exp_instr,
                                input logic exp_mis);
        cyc(1'b0, st, 1'b1, ty, tg);
        chk({nm, " req in redirect"}, {31'd0, last_req}, 32'd0);
        chk({nm, " valid E0"}, {31'd0, bus.if_id_valid}, 32'd0);
        chk({nm, " nextpc E0"}, bus.if_id_nextpc, exp_pc);
        chk({nm, " count E0"}, {29'd0, bus.fq_count}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk({nm, " misalign E0"}, {31'd0, bus.if_misalign}, {31'd0, exp_mis});
`else
        if (exp_mis) chk({nm, " aligned nextpc"}, {30'd0, bus.if_id_nextpc[1:0]}, 32'd0);
`endif
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
        chk({nm, " valid E1"}, {31'd0, bus.if_id_valid}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk({nm, " misalign E1"}, {31'd0, bus.if_misalign}, 32'd0);
`endif
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
        chk({nm, " valid E2"}, {31'd0, bus.if_id_valid}, 32'd1);
        chk({nm, " instr E2"}, bus.if_id_instruc, exp_instr);
        chk({nm, " nextpc E2"}, bus.if_id_nextpc, exp_pc + 32'd4);
    endtask

    initial begin
        bus.imem_rdata = '0;
        tv[0]  = mk(1, 0, 0, 0, 0,     0, 0, 32'h0,         32'h0,   0);
        tv[1]  = mk(0, 0, 0, 0, 0,     1, 0, 32'h0,         32'h0,   0);
        tv[2]  = mk(0, 0, 0, 0, 0,     1, 1, 32'hA000_0000, 32'd4,   0);
        tv[3]  = mk(0, 0, 0, 0, 0,     1, 1, 32'hA000_0001, 32'd8,   0);
        tv[4]  = mk(0, 0, 0, 0, 0,     1, 1, 32'hA000_0002, 32'd12,  0);
        tv[5]  = mk(0, 1, 0, 0, 0,     1, 1, 32'hA000_0002, 32'd12,  1);
        tv[6]  = mk(0, 1, 0, 0, 0,     1, 1, 32'hA000_0002, 32'd12,  2);
        tv[7]  = mk(0, 1, 0, 0, 0,     1, 1, 32'hA000_0002, 32'd12,  3);
        tv[8]  = mk(0, 1, 0, 0, 0,     0, 1, 32'hA000_0002, 32'd12,  4);
        tv[9]  = mk(0, 1, 0, 0, 0,     0, 1, 32'hA000_0002, 32'd12,  4);
        tv[10] = mk(0, 1, 0, 0, 0,     0, 1, 32'hA000_0002, 32'd12,  4);
        tv[11] = mk(0, 0, 0, 0, 0,     0, 1, 32'hA000_0003, 32'd16,  3);
        tv[12] = mk(0, 0, 0, 0, 0,     1, 1, 32'hA000_0004, 32'd20,  2);
        tv[13] = mk(0, 0, 0, 0, 0,     1, 1, 32'hA000_0005, 32'd24,  2);
        tv[14] = mk(0, 0, 0, 0, 0,     1, 1, 32'hA000_0006, 32'd28,  2);
        tv[15] = mk(0, 0, 0, 0, 0,     1, 1, 32'hA000_0007, 32'd32,  2);
        tv[16] = mk(0, 1, 0, 0, 0,     1, 1, 32'hA000_0007, 32'd32,  3);
        tv[17] = mk(0, 0, 1, 0, 32'h100, 0, 0, 32'hA000_0007, 32'h100, 0);
        tv[18] = mk(0, 0, 0, 0, 0,     1, 0, 32'hA000_0007, 32'h100, 0);
        tv[19] = mk(0, 0, 0, 0, 0,     1, 1, 32'hA000_0040, 32'h104, 0);
        tv[20] = mk(0, 0, 0, 0, 0,     1, 1, 32'hA000_0041, 32'h108, 0);

        for (int i = 0; i < 21; i++) begin
            cyc(tv[i].rst, tv[i].stall, tv[i].sel, tv[i].typ, tv[i].tgt);
            chk($sformatf("vec%0d req", i), {31'd0, last_req}, {31'd0, tv[i].req});
            chk($sformatf("vec%0d valid", i), {31'd0, bus.if_id_valid}, {31'd0, tv[i].valid});
            chk($sformatf("vec%0d instr", i), bus.if_id_instruc, tv[i].instr);
            chk($sformatf("vec%0d nextpc", i), bus.if_id_nextpc, tv[i].nextpc);
            chk($sformatf("vec%0d count", i), {29'd0, bus.fq_count}, {29'd0, tv[i].count});
        end

        redirect_seq("exc_vec_stalled", 2'b11, 32'h0, 1'b1, 32'h40,  32'hA000_0010, 1'b0);
        redirect_seq("rega_wrap",       2'b01, 32'h200, 1'b0, 32'h200, 32'hA000_0000, 1'b0);
        redirect_seq("pcindex",         2'b10, 32'h30, 1'b0, 32'h30,  32'hA000_000C, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        redirect_seq("misaligned",      2'b00, 32'h102, 1'b0, 32'h40, 32'hA000_0010, 1'b1);
`else
        redirect_seq("misaligned",      2'b00, 32'h102, 1'b0, 32'h100, 32'hA000_0040, 1'b1);
`endif

        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 2'b00, 32'd0);
        chk("full count", {29'd0, bus.fq_count}, 32'd4);
        chk("full req", {31'd0, last_req}, 32'd0);

        cyc(1'b1, 1'b1, 1'b1, 2'b00, 32'h100);
        chk("rst req", {31'd0, last_req}, 32'd0);
        chk("rst valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("rst instr", bus.if_id_instruc, 32'd0);
        chk("rst nextpc", bus.if_id_nextpc, 32'd0);
        chk("rst count", {29'd0, bus.fq_count}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst misalign", {31'd0, bus.if_misalign}, 32'd0);
`endif
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
        chk("restart req", {31'd0, last_req}, 32'd1);
        chk("restart valid E1", {31'd0, bus.if_id_valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'd0);
        chk("restart valid E2", {31'd0, bus.if_id_valid}, 32'd1);
        chk("restart instr", bus.if_id_instruc, 32'hA000_0000);
        chk("restart nextpc", bus.if_id_nextpc, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a prefetch queue, placed between the instruction memory and Decode. It keeps a PC and issues sequential read requests to a synchronous instruction memory. Returned words are buffered in a DEPTH-entry FIFO, so fetch keeps running while Decode stalls. Redirects from Decode (branch, register jump, index jump, exception vector) flush all buffered and in-flight instructions and restart fetch at the target.

## Interface
- ADDR_W, 32, PC width in bits
- DATA_W, 32, instruction width in bits
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- IMEM_AW, 7, instruction memory word-address width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- EXC_VECTOR, 32'h0000_0040, target for selpctype 2'b11

- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  reset; synchronous and active-high
- id_stall  in  1  Decode cannot accept an instruction this cycle
- id_if_selpcsource  in  1  redirect request
- id_if_selpctype  in  2  redirect source: 00 pcimd2ext, 01 rega, 10 pcindex, 11 EXC_VECTOR
- id_if_rega, id_if_pcimd2ext, id_if_pcindex  in  ADDR_W each  redirect targets
- imem_req  out  1  read request
- imem_addr  out  IMEM_AW  word address = pc[IMEM_AW+1:2]
- imem_rdata  in  DATA_W  read data, valid one cycle after imem_req
- if_id_valid  out  1  if_id_instruc holds a live instruction
- if_id_instruc  out  DATA_W  instruction to Decode
- if_id_nextpc  out  ADDR_W  address of that instruction + 4
- fq_count  out  $clog2(DEPTH)+1  current queue occupancy
- if_misalign  out  1  only with FETCH_ALIGN_CHECK_EN: misaligned redirect trapped

## Operation
- State:
  - pc.
  - inflight bit, plus inflight tag = request pc + 4.
  - Queue of {nextpc, instr} with rd/wr pointers and count.
  - Output register {valid, instr, nextpc}.
- Issue: imem_req = !reset && !redirect && (fq_count + inflight) < DEPTH.
  - When imem_req is high, pc advances by 4 and inflight is set with tag pc+4.
  - Otherwise inflight clears.
- Response: when inflight is high, imem_rdata and the tag form one entry.
  - Bypass: if the queue is empty and the output register loads this cycle, the entry goes straight into the output register.
  - Otherwise it is pushed into the queue.
- Output load: when !id_stall, the output register takes the queue head (pop) if the queue is non-empty, else the bypass entry, else a bubble (valid=0, instr and nextpc hold).
- id_stall high: the output register holds every field. Responses still push into the queue.
- Redirect (id_if_selpcsource=1) is honoured in any cycle and overrides id_stall:
  - pc ← selected target; queue count and pointers cleared; inflight cleared and its response discarded.
  - if_id_valid ← 0; if_id_nextpc ← target.
  - No request is issued in the redirect cycle.
- Target low two bits are handled per Configuration.
- Queue wrap: pointers are log2(DEPTH) bits and wrap naturally.
- Overflow is impossible by credit rule. Pop on empty never happens: bypass/bubble applies.
- pc arithmetic is modulo 2^ADDR_W. imem_addr wraps within IMEM_AW.

## Timing
- Reset (sampled at edge E0):
  - pc=RESET_PC; queue empty; inflight=0.
  - if_id_valid=0, if_id_instruc=0, if_id_nextpc=0, fq_count=0, if_misalign=0.
  - imem_req is 0 while reset is high.
- After reset falls, the first request goes out in the cycle after E0. That instruction is valid after edge E2 via bypass.
- Redirect sampled at edge E0: request to the target between E0 and E1; target instruction valid after E2. Redirect-to-valid is 2 edges.
- Steady state without stall: one instruction per cycle, fq_count stays 0.
- Stall of k cycles with DEPTH ≥ 2: the queue fills to DEPTH, then imem_req drops. On release, one instruction per cycle, with no bubble.
- Reset mid-operation overrides redirect and stall in the same cycle.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with target[1:0] ≠ 0 loads pc and if_id_nextpc with EXC_VECTOR instead of the target.
  - if_misalign pulses high for exactly one cycle, after the redirect edge.
- Undefined:
  - The if_misalign port is absent.
  - target[1:0] is forced to 00 and fetch proceeds from the aligned address.

## Test plan
- Reset, no stall, memory word n = 32'hA000_0000+n → if_id_valid rises after 2nd edge; instrs A0000000, A0000001, … one per cycle; nextpc 4, 8, 12…; fq_count=0.
- id_stall high 6 cycles mid-stream (DEPTH=4) → outputs frozen; fq_count reaches 4; imem_req low once full; after release instrs resume in order with no gap and no duplicate.
- Redirect selpctype=00, pcimd2ext=0x100, while queue holds 3 entries → fq_count=0 next cycle; bubble; instruction from word 0x40 (addr 0x100) valid after 2 edges with nextpc 0x104; no stale instruction emitted.
- Redirect with selpctype=11 while id_stall=1 → redirect taken; nextpc=0x44 on the first valid after 2 edges.
- Redirect to 0x102: with FETCH_ALIGN_CHECK_EN → if_misalign one-cycle pulse, fetch from 0x40; without → fetch from 0x100.
- Reset asserted with full queue and inflight → all outputs at reset values next cycle; restart from RESET_PC.
